// File: rtl/dot_issue_arbiter.sv
// Round-robin issue arbiter for one shared, fully pipelined dot-product unit.
// An ID tag travels alongside each issued op so its result can be steered back
// to the requester that issued it; a tag/result disagreement sets a sticky error.
module dot_issue_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int N           = 3,
  parameter int A_WIDTH     = 25,
  parameter int B_WIDTH     = 18,
  parameter int P_WIDTH     = 32,
  parameter int DOT_LATENCY = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         enable_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ*N*A_WIDTH-1:0] req_a_in,
  input  logic [NUM_REQ*N*B_WIDTH-1:0] req_b_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  output logic                         dot_valid_out,
  output logic [N*A_WIDTH-1:0]         dot_a_out,
  output logic [N*B_WIDTH-1:0]         dot_b_out,
  input  logic                         dot_valid_in,
  input  logic [P_WIDTH-1:0]           dot_p_in,
  output logic [NUM_REQ-1:0]           resp_valid_out,
  output logic [P_WIDTH-1:0]           resp_p_out,
  output logic                         busy_out,
  output logic                         protocol_err_out
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AV_W = N * A_WIDTH;
  localparam int BV_W = N * B_WIDTH;

  logic [ID_W-1:0]        r_ptr;
  logic                   r_dot_valid;
  logic [ID_W-1:0]        r_dot_id;
  logic [AV_W-1:0]        r_dot_a;
  logic [BV_W-1:0]        r_dot_b;
  logic [DOT_LATENCY-1:0] r_tag_v;
  logic [ID_W-1:0]        r_tag_id [DOT_LATENCY];
  logic [NUM_REQ-1:0]     r_resp_valid;
  logic [P_WIDTH-1:0]     r_resp_p;
  logic                   r_err;

  logic                   w_en;
  logic [NUM_REQ-1:0]     w_hi;
  logic [NUM_REQ-1:0]     w_lo;
  logic [ID_W-1:0]        w_sel_hi;
  logic [ID_W-1:0]        w_sel_lo;
  logic                   w_hs;
  logic [ID_W-1:0]        w_gnt_id;
  logic [NUM_REQ-1:0]     w_grant;
  logic [ID_W-1:0]        w_ptr_nxt;
  logic [AV_W-1:0]        w_a;
  logic [BV_W-1:0]        w_b;
  logic                   w_last_v;
  logic [ID_W-1:0]        w_last_id;

  // Ready is gated by reset as well so every output reads 0 while held in reset.
  assign w_en = enable_in & rst_n_in;

  // Round-robin pick: valid requesters at/above ptr win first, else wrap to the lowest below ptr.
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_sel_hi = '0;
    w_sel_lo = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_en && req_valid_in[i]) begin
        if (ID_W'(i) >= r_ptr) w_hi[i] = 1'b1;
        else                   w_lo[i] = 1'b1;
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_hi[i]) w_sel_hi = ID_W'(i);
      if (w_lo[i]) w_sel_lo = ID_W'(i);
    end
    w_hs     = (|w_hi) | (|w_lo);
    w_gnt_id = (|w_hi) ? w_sel_hi : w_sel_lo;
  end

  // One-hot grant and the pointer value that follows it.
  always_comb begin
    w_grant   = w_hs ? (NUM_REQ'(1) << w_gnt_id) : '0;
    w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = req_a_in[i*AV_W +: AV_W];
        w_b = req_b_in[i*BV_W +: BV_W];
      end
    end
  end

  // Pointer advances past the winner; holds when nothing is granted.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)  r_ptr <= '0;
    else if (w_hs)  r_ptr <= w_ptr_nxt;
  end

  // Issue register: strobe every cycle, operands and ID only reload on a handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_dot_valid <= 1'b0;
      r_dot_id    <= '0;
      r_dot_a     <= '0;
      r_dot_b     <= '0;
    end else begin
      r_dot_valid <= w_hs;
      if (w_hs) begin
        r_dot_id <= w_gnt_id;
        r_dot_a  <= w_a;
        r_dot_b  <= w_b;
      end
    end
  end

  // Tag pipe fed from the issue register so the last stage lines up with the unit's result.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_tag_v <= '0;
      for (int k = 0; k < DOT_LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      r_tag_v[0]  <= r_dot_valid;
      r_tag_id[0] <= r_dot_id;
      for (int k = 1; k < DOT_LATENCY; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_last_v  = r_tag_v[DOT_LATENCY-1];
  assign w_last_id = r_tag_id[DOT_LATENCY-1];

  // Return path: only a matched tag+result produces a response; orphans are dropped.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_resp_valid <= '0;
      r_resp_p     <= '0;
    end else if (w_last_v && dot_valid_in) begin
      r_resp_valid <= NUM_REQ'(1) << w_last_id;
      r_resp_p     <= dot_p_in;
    end else begin
      r_resp_valid <= '0;
    end
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                     r_err <= 1'b0;
    else if (w_last_v ^ dot_valid_in)  r_err <= 1'b1;
  end

  assign req_ready_out    = w_grant;
  assign dot_valid_out    = r_dot_valid;
  assign dot_a_out        = r_dot_a;
  assign dot_b_out        = r_dot_b;
  assign resp_valid_out   = r_resp_valid;
  assign resp_p_out       = r_resp_p;
  assign busy_out         = r_dot_valid | (|r_tag_v);
  assign protocol_err_out = r_err;

endmodule
